// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: fetch PC, one-word I-cache requests, BTB next-PC prediction.
// Define IF_BTB_EN to build the direct-mapped BTB; otherwise the next PC is always PC+4.
module inst_fetch #(
  parameter int          BTB_ENTRIES = 32,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        roll,
  input  logic [31:0] roll_PC,
  output logic        IC_req,
  output logic [31:0] IC_addr,
  input  logic        IC_valid,
  input  logic [31:0] IC_inst,
  input  logic        IQ_full,
  output logic        IF_flag,
  output logic [31:0] IF_inst,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_BTB_PC,
  output logic        IF_BTB_predict,
  input  logic        BR_flag,
  input  logic [31:0] BR_PC,
  input  logic [31:0] BR_target,
  input  logic        BR_taken
);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pred_taken;
  logic [31:0] pred_pc;

  assign pc_plus4 = pc + 32'd4;

`ifdef IF_BTB_EN
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IW;

  logic          btb_valid  [BTB_ENTRIES];
  logic [TW-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]   btb_target [BTB_ENTRIES];
  logic [1:0]    btb_cnt    [BTB_ENTRIES];
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          rd_hit;
  logic          wr_hit;
  logic          unused_br_lsb;

  assign rd_idx        = pc[IW+1:2];
  assign wr_idx        = BR_PC[IW+1:2];
  assign rd_hit        = btb_valid[rd_idx] && (btb_tag[rd_idx] == pc[31:IW+2]);
  assign wr_hit        = btb_valid[wr_idx] && (btb_tag[wr_idx] == BR_PC[31:IW+2]);
  assign pred_taken    = rd_hit && btb_cnt[rd_idx][1];
  assign pred_pc       = pred_taken ? btb_target[rd_idx] : pc_plus4;
  assign unused_br_lsb = ^BR_PC[1:0];

  // Lookup reads the arrays combinationally, so a same-cycle update is seen one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_cnt[i]    <= 2'b00;
      end
    end else if (rdy && BR_flag) begin
      if (wr_hit) begin
        if (BR_taken) begin
          btb_target[wr_idx] <= BR_target;
          if (btb_cnt[wr_idx] != 2'b11) btb_cnt[wr_idx] <= btb_cnt[wr_idx] + 2'd1;
        end else if (btb_cnt[wr_idx] != 2'b00) begin
          btb_cnt[wr_idx] <= btb_cnt[wr_idx] - 2'd1;
        end
      end else if (BR_taken) begin
        btb_valid[wr_idx]  <= 1'b1;
        btb_tag[wr_idx]    <= BR_PC[31:IW+2];
        btb_target[wr_idx] <= BR_target;
        btb_cnt[wr_idx]    <= 2'b10;
      end
    end
  end
`else
  logic unused_br;

  assign pred_taken = 1'b0;
  assign pred_pc    = pc_plus4;
  assign unused_br  = ^{BR_flag, BR_taken, BR_PC, BR_target, BTB_ENTRIES != 0};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      IC_req         <= 1'b0;
      IC_addr        <= '0;
      IF_flag        <= 1'b0;
      IF_inst        <= '0;
      IF_PC          <= '0;
      IF_BTB_PC      <= '0;
      IF_BTB_predict <= 1'b0;
    end else if (rdy) begin
      IF_flag <= 1'b0;
      if (roll) begin
        // An outstanding request still owes one response; swallow it in FLUSH.
        pc     <= roll_PC;
        IC_req <= 1'b0;
        if ((state == WAIT || state == FLUSH) && !IC_valid) state <= FLUSH;
        else                                                 state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (!IQ_full && !IF_flag) begin
              IC_req  <= 1'b1;
              IC_addr <= pc;
              state   <= WAIT;
            end
          end
          WAIT: begin
            if (IC_valid) begin
              IF_flag        <= 1'b1;
              IF_inst        <= IC_inst;
              IF_PC          <= pc;
              IF_BTB_PC      <= pred_pc;
              IF_BTB_predict <= pred_taken;
              pc             <= pred_pc;
              IC_req         <= 1'b0;
              state          <= IDLE;
            end
          end
          FLUSH: begin
            if (IC_valid) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized self-checking bench for inst_fetch against a transaction-level model.
module tb_inst_fetch;
  localparam int NE = 32;
`ifdef IF_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic        roll = 1'b0;
  logic [31:0] roll_PC = '0;
  logic        IC_req;
  logic [31:0] IC_addr;
  logic        IC_valid = 1'b0;
  logic [31:0] IC_inst = '0;
  logic        IQ_full = 1'b0;
  logic        IF_flag;
  logic [31:0] IF_inst, IF_PC, IF_BTB_PC;
  logic        IF_BTB_predict;
  logic        BR_flag = 1'b0;
  logic [31:0] BR_PC = '0;
  logic [31:0] BR_target = '0;
  logic        BR_taken = 1'b0;

  always #5 clk = ~clk;

  inst_fetch #(.BTB_ENTRIES(NE), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .roll(roll), .roll_PC(roll_PC),
    .IC_req(IC_req), .IC_addr(IC_addr), .IC_valid(IC_valid), .IC_inst(IC_inst),
    .IQ_full(IQ_full), .IF_flag(IF_flag), .IF_inst(IF_inst), .IF_PC(IF_PC),
    .IF_BTB_PC(IF_BTB_PC), .IF_BTB_predict(IF_BTB_predict),
    .BR_flag(BR_flag), .BR_PC(BR_PC), .BR_target(BR_target), .BR_taken(BR_taken)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding-request bookkeeping plus a BTB table keyed by word index.
  logic [31:0] m_pc, m_addr, m_inst, m_ipc, m_bpc;
  bit          m_req, m_flag, m_pred, m_busy, m_disc;
  bit          b_val [NE];
  int unsigned b_tag [NE];
  logic [31:0] b_tgt [NE];
  int          b_cnt [NE];
  int          n_push = 0;
  logic [31:0] q_pc[$];
  logic [31:0] q_bpc[$];
  bit          q_pred[$];

  task automatic model_reset();
    m_pc = 32'h0; m_addr = '0; m_inst = '0; m_ipc = '0; m_bpc = '0;
    m_req = 0; m_flag = 0; m_pred = 0; m_busy = 0; m_disc = 0;
    for (int i = 0; i < NE; i++) begin
      b_val[i] = 0; b_tag[i] = 0; b_tgt[i] = '0; b_cnt[i] = 0;
    end
  endtask

  task automatic model_step();
    int          idx, widx;
    bit          tk, prev_flag;
    logic [31:0] nxt;
    if (!rst_n) begin
      model_reset();
    end else if (rdy) begin
      idx = int'((m_pc >> 2) % NE);
      tk  = BTB_ON && b_val[idx] && (b_tag[idx] == (m_pc >> 7)) && (b_cnt[idx] >= 2);
      nxt = tk ? b_tgt[idx] : m_pc + 32'd4;
      prev_flag = m_flag;
      m_flag = 0;
      if (roll) begin
        if (m_busy) m_disc = !IC_valid;
        else if (m_disc && IC_valid) m_disc = 0;
        m_busy = 0; m_req = 0; m_pc = roll_PC;
      end else if (m_disc) begin
        if (IC_valid) m_disc = 0;
      end else if (m_busy) begin
        if (IC_valid) begin
          m_flag = 1; m_inst = IC_inst; m_ipc = m_pc; m_bpc = nxt; m_pred = tk;
          m_pc = nxt; m_req = 0; m_busy = 0;
          n_push++; q_pc.push_back(m_ipc); q_bpc.push_back(nxt); q_pred.push_back(tk);
        end
      end else if (!IQ_full && !prev_flag) begin
        m_req = 1; m_addr = m_pc; m_busy = 1;
      end
      if (BTB_ON && BR_flag) begin
        widx = int'((BR_PC >> 2) % NE);
        if (b_val[widx] && b_tag[widx] == (BR_PC >> 7)) begin
          if (BR_taken) begin
            b_tgt[widx] = BR_target;
            if (b_cnt[widx] < 3) b_cnt[widx]++;
          end else if (b_cnt[widx] > 0) begin
            b_cnt[widx]--;
          end
        end else if (BR_taken) begin
          b_val[widx] = 1; b_tag[widx] = BR_PC >> 7; b_tgt[widx] = BR_target; b_cnt[widx] = 2;
        end
      end
    end
  endtask

  // Cache model: answers each request after c_lat enabled cycles, even if the request is withdrawn.
  bit c_pend = 0;
  int c_cnt = 0;
  int c_lat = 1;
  bit c_last_rdy = 0;
  bit rolled = 0;

  task automatic cyc(input bit r, input bit rl, input logic [31:0] rpc, input bit full,
                     input bit bf, input logic [31:0] bpc, input logic [31:0] btg,
                     input bit btk, input bit rov);
    if (IC_valid) c_pend = 0;
    else if (c_pend && c_last_rdy) c_cnt--;
    if (!c_pend && IC_req) begin c_pend = 1; c_cnt = c_lat; end
    rdy       = r;
    IC_valid  = c_pend && (c_cnt <= 0) && r;
    IC_inst   = $urandom;
    roll      = rov ? IC_valid : rl;
    if (roll && r) rolled = 1;
    roll_PC   = rpc;
    IQ_full   = full;
    BR_flag   = bf;
    BR_PC     = bpc;
    BR_target = btg;
    BR_taken  = btk;
    c_last_rdy = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic wait_push(input int target, input int budget, input string name);
    int k = 0;
    while (n_push < target && k < budget) begin idle(); k++; end
    if (n_push < target) begin
      tests++; fails++;
      $display("FAIL %s: timeout, pushes %0d, required %0d", name, n_push, target);
    end
  endtask

  task automatic wait_req(input int budget, input string name);
    int k = 0;
    while (!m_req && k < budget) begin idle(); k++; end
    if (!m_req) begin
      tests++; fails++;
      $display("FAIL %s: timeout waiting for IC_req, got 0 required 1", name);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("IC_req", IC_req, m_req);
      chk("IC_addr", IC_addr, m_addr);
      chk("IF_flag", IF_flag, m_flag);
      chk("IF_inst", IF_inst, m_inst);
      chk("IF_PC", IF_PC, m_ipc);
      chk("IF_BTB_PC", IF_BTB_PC, m_bpc);
      chk("IF_BTB_predict", IF_BTB_predict, m_pred);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          k;
    logic [31:0] s_addr, s_inst, s_ipc, s_bpc;
    bit          s_req, s_flag, s_pred;

    model_reset();
    @(negedge clk);
    idle(); idle();
    chk("rst_IC_req", IC_req, 32'h0);
    chk("rst_IC_addr", IC_addr, 32'h0);
    chk("rst_IF_flag", IF_flag, 32'h0);
    chk("rst_IF_inst", IF_inst, 32'h0);
    chk("rst_IF_PC", IF_PC, 32'h0);
    chk("rst_IF_BTB_PC", IF_BTB_PC, 32'h0);
    chk("rst_IF_BTB_predict", IF_BTB_predict, 32'h0);
    rst_n = 1'b1;

    c_lat = 1;
    wait_push(3, 40, "seq_push");
    chk("seq_pc0", q_pc[0], 32'h0);
    chk("seq_pc1", q_pc[1], 32'h4);
    chk("seq_pc2", q_pc[2], 32'h8);
    chk("seq_bpc0", q_bpc[0], 32'h4);
    chk("seq_bpc2", q_bpc[2], 32'hC);
    chk("seq_pred1", q_pred[1], 32'h0);

    base = n_push;
    cyc(1, 0, 32'h0, 0, 1, 32'h8, 32'h40, 1, 0);
    cyc(1, 1, 32'h8, 0, 0, 32'h0, 32'h0, 0, 0);
    wait_push(base + 2, 60, "btb_push");
    chk("btb_pc", q_pc[base], 32'h8);
    chk("btb_pred", q_pred[base], BTB_ON ? 32'h1 : 32'h0);
    chk("btb_bpc", q_bpc[base], BTB_ON ? 32'h40 : 32'hC);
    chk("btb_next_pc", q_pc[base + 1], BTB_ON ? 32'h40 : 32'hC);

    base = n_push;
    cyc(1, 0, 32'h0, 0, 1, 32'h8, 32'h0, 0, 0);
    cyc(1, 0, 32'h0, 0, 1, 32'h8, 32'h0, 0, 0);
    cyc(1, 1, 32'h8, 0, 0, 32'h0, 32'h0, 0, 0);
    wait_push(base + 1, 60, "nt_push");
    chk("nt_pc", q_pc[base], 32'h8);
    chk("nt_pred", q_pred[base], 32'h0);
    chk("nt_bpc", q_bpc[base], 32'hC);

    k = 0;
    while (!m_flag && k < 40) begin idle(); k++; end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0, 0);
      chk("full_IC_req", IC_req, 32'h0);
      chk("full_IF_flag", IF_flag, 32'h0);
    end
    cyc(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("full_resume", IC_req, 32'h1);

    c_lat = 2;
    base = n_push;
    cyc(1, 1, 32'h100, 0, 0, 32'h0, 32'h0, 0, 0);
    wait_req(30, "flush_req");
    chk("flush_no_push", n_push, base);
    chk("flush_addr", IC_addr, 32'h100);

    idle();
    s_req = m_req; s_addr = m_addr; s_flag = m_flag; s_inst = m_inst;
    s_ipc = m_ipc; s_bpc = m_bpc; s_pred = m_pred;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 32'h0, 0, 1, 32'h8, 32'h0, 1, 0);
      chk("frz_IC_req", IC_req, s_req);
      chk("frz_IC_addr", IC_addr, s_addr);
      chk("frz_IF_flag", IF_flag, s_flag);
      chk("frz_IF_inst", IF_inst, s_inst);
      chk("frz_IF_PC", IF_PC, s_ipc);
      chk("frz_IF_BTB_PC", IF_BTB_PC, s_bpc);
      chk("frz_IF_BTB_predict", IF_BTB_predict, s_pred);
    end
    base = n_push;
    rolled = 0;
    k = 0;
    while (!rolled && k < 10) begin cyc(1, 0, 32'h200, 0, 0, 32'h0, 32'h0, 0, 1); k++; end
    chk("coinc_rolled", rolled, 32'h1);
    wait_req(30, "coinc_req");
    chk("coinc_no_push", n_push, base);
    chk("coinc_addr", IC_addr, 32'h200);

    wait_req(30, "rst_mid_req");
    rst_n = 1'b0;
    #1;
    chk("rstmid_IC_req", IC_req, 32'h0);
    chk("rstmid_IC_addr", IC_addr, 32'h0);
    chk("rstmid_IF_PC", IF_PC, 32'h0);
    model_reset();
    c_pend = 0; IC_valid = 0; roll = 0;
    idle(); idle();
    rst_n = 1'b1;
    c_lat = 1;
    base = n_push;
    wait_push(base + 1, 40, "rstmid_push");
    chk("rstmid_pc", q_pc[base], 32'h0);

    for (int i = 0; i < 3000; i++) begin
      c_lat = int'($urandom_range(1, 3));
      cyc(($urandom % 10) != 0, ($urandom % 30) == 0, {22'h0, 8'($urandom), 2'b00},
          ($urandom % 5) == 0, ($urandom % 8) == 0, {22'h0, 8'($urandom), 2'b00},
          {22'h0, 8'($urandom), 2'b00}, 1'($urandom), ($urandom % 25) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
